// File: rtl/soc_system_limit_guard.sv
// rtl/soc_system_limit_guard.sv - limit-switch guard: debounce, edge capture, IRQ, sticky motor inhibit (option macro LIMIT_GUARD_BOTHEDGE_EN)
module soc_system_limit_guard #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq,
  output logic [WIDTH-1:0] motor_inhibit
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_IRQMASK = 3'd1;
  localparam logic [2:0] ADDR_EDGECAP = 3'd2;
  localparam logic [2:0] ADDR_INHMASK = 3'd3;
  localparam logic [2:0] ADDR_FAULT   = 3'd4;

  // Terminal count: the level is accepted on the DEBOUNCE_CYCLES-th consecutive differing cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_ff1;
  logic [WIDTH-1:0] sync_ff2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [CNT_W-1:0] cnt [WIDTH];

  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] inh_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] fault;

  logic             wr_en;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] fault_clr;
  logic [WIDTH-1:0] fault_set;
  logic [31:0]      read_mux;

  assign wr_en   = chipselect & ~write_n;
  assign wr_bits = writedata[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_unused_wdata
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:WIDTH];
    end
  endgenerate

  assign rise = stable & ~stable_d;

`ifdef LIMIT_GUARD_BOTHEDGE_EN
  assign edge_evt = stable ^ stable_d;
`else
  assign edge_evt = rise;
`endif

  assign edge_clr  = (wr_en && address == ADDR_EDGECAP) ? wr_bits : '0;
  assign fault_clr = (wr_en && address == ADDR_FAULT)   ? wr_bits : '0;
  // A still-active masked limit keeps re-arming its fault, so W1C cannot drop it.
  assign fault_set = (rise | stable) & inh_mask;

  assign irq           = |(edge_cap & irq_mask);
  assign motor_inhibit = fault;

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_ff1 <= '0;
      sync_ff2 <= '0;
    end else begin
      sync_ff1 <= in_port;
      sync_ff2 <= sync_ff1;
    end
  end

  // Per-bit debounce: accept a new level only after it held for the full window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_ff2[i] != stable[i]) begin
          if (cnt[i] == CNT_LAST) begin
            stable[i] <= sync_ff2[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stable_d <= '0;
    else       stable_d <= stable;
  end

  // Writable mask registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask <= '0;
      inh_mask <= '0;
    end else if (wr_en) begin
      if (address == ADDR_IRQMASK) irq_mask <= wr_bits;
      if (address == ADDR_INHMASK) inh_mask <= wr_bits;
    end
  end

  // Sticky edge capture and fault latches; a set in the same cycle beats the W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cap <= '0;
      fault    <= '0;
    end else begin
      edge_cap <= (edge_cap & ~edge_clr) | edge_evt;
      fault    <= (fault & ~fault_clr) | fault_set;
    end
  end

  // Read data selection; unmapped addresses and unused bits read as zero.
  always_comb begin
    read_mux = '0;
    case (address)
      ADDR_DATA:    read_mux[WIDTH-1:0] = stable;
      ADDR_IRQMASK: read_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: read_mux[WIDTH-1:0] = edge_cap;
      ADDR_INHMASK: read_mux[WIDTH-1:0] = inh_mask;
      ADDR_FAULT:   read_mux[WIDTH-1:0] = fault;
      default:      read_mux = '0;
    endcase
  end

  // Registered read port, holding its value when not selected.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           readdata <= '0;
    else if (chipselect) readdata <= read_mux;
  end

endmodule

// File: tb/tb_soc_system_limit_guard.sv
// tb/tb_soc_system_limit_guard.sv - self-checking bench for soc_system_limit_guard
module tb_soc_system_limit_guard;

  localparam int D = 4;

`ifdef LIMIT_GUARD_BOTHEDGE_EN
  localparam logic [31:0] FALL_CAP_EXP = 32'h0000_0008;
`else
  localparam logic [31:0] FALL_CAP_EXP = 32'h0000_0000;
`endif

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic        irq;
  logic [7:0]  motor_inhibit;

  int n_cmp = 0;
  int n_bad = 0;

  soc_system_limit_guard #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq), .motor_inhibit(motor_inhibit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: the debounced level flips once the last D synchronized samples all disagree with it.
  logic [7:0]  m_hist[$];
  logic [7:0]  m_stable, m_prev, m_irqmask, m_inhmask, m_edgecap, m_fault;
  logic [31:0] m_readdata;

  task automatic model_clear();
    m_hist.delete();
    for (int j = 0; j < D + 2; j++) m_hist.push_back(8'h00);
    m_stable = 0; m_prev = 0; m_irqmask = 0; m_inhmask = 0;
    m_edgecap = 0; m_fault = 0; m_readdata = 0;
  endtask

  task automatic model_step();
    logic [7:0] nxt, rise_v, evt, bits;
    logic       wr, diff;
    wr   = chipselect & ~write_n;
    bits = writedata[7:0];
    m_hist.push_back(in_port);
    void'(m_hist.pop_front());
    nxt = m_stable;
    for (int i = 0; i < 8; i++) begin
      diff = 1'b1;
      for (int j = 0; j < D; j++) if (m_hist[j][i] == m_stable[i]) diff = 1'b0;
      if (diff) nxt[i] = ~m_stable[i];
    end
    rise_v = m_stable & ~m_prev;
`ifdef LIMIT_GUARD_BOTHEDGE_EN
    evt = m_stable ^ m_prev;
`else
    evt = rise_v;
`endif
    if (chipselect) begin
      case (address)
        3'd0: m_readdata = {24'h0, m_stable};
        3'd1: m_readdata = {24'h0, m_irqmask};
        3'd2: m_readdata = {24'h0, m_edgecap};
        3'd3: m_readdata = {24'h0, m_inhmask};
        3'd4: m_readdata = {24'h0, m_fault};
        default: m_readdata = 32'h0;
      endcase
    end
    m_edgecap = (m_edgecap & ~((wr && address == 3'd2) ? bits : 8'h00)) | evt;
    m_fault   = (m_fault & ~((wr && address == 3'd4) ? bits : 8'h00)) | ((rise_v | m_stable) & m_inhmask);
    if (wr && address == 3'd1) m_irqmask = bits;
    if (wr && address == 3'd3) m_inhmask = bits;
    m_prev   = m_stable;
    m_stable = nxt;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_clear();
      else       model_step();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the DUT against the model every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("model_readdata", readdata, m_readdata);
      check("model_irq", {31'h0, irq}, {31'h0, |(m_edgecap & m_irqmask)});
      check("model_inhibit", {24'h0, motor_inhibit}, {24'h0, m_fault});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    tick(1);
    chipselect = 1'b0;
    d = readdata;
  endtask

  logic [31:0] r;

  initial begin
    reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; in_port = 8'h00;
    tick(2);
    reset = 1'b0;
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    check("reset_inhibit", {24'h0, motor_inhibit}, 32'h0);

    // Debounce latency on bit 0, observed through a continuous DATA read.
    chipselect = 1'b1; address = 3'd0; in_port = 8'h01;
    tick(6);
    check("latency_before", readdata, 32'h0);
    tick(1);
    check("latency_at", readdata, 32'h1);
    chipselect = 1'b0;

    // Short pulse on bit 1 must be rejected.
    in_port = 8'h03; tick(3); in_port = 8'h01; tick(10);
    rd(3'd0, r); check("pulse_data", r, 32'h1);
    rd(3'd2, r); check("pulse_edgecap", r, 32'h1);
    check("pulse_irq", {31'h0, irq}, 32'h0);

    // IRQ set and W1C.
    wr(3'd2, 32'h1); wr(3'd1, 32'h1);
    in_port = 8'h00; tick(8); wr(3'd2, 32'hFF);
    rd(3'd2, r); check("irq_cleared_cap", r, 32'h0);
    in_port = 8'h01; tick(8);
    rd(3'd2, r); check("irq_cap_set", r, 32'h1);
    check("irq_high", {31'h0, irq}, 32'h1);
    wr(3'd2, 32'h1);
    check("irq_w1c", {31'h0, irq}, 32'h0);
    rd(3'd2, r); check("irq_w1c_cap", r, 32'h0);

    // W1C landing on the rise cycle loses to the set.
    in_port = 8'h00; tick(8); wr(3'd2, 32'hFF);
    in_port = 8'h01; tick(6); wr(3'd2, 32'h1);
    check("setwins_irq", {31'h0, irq}, 32'h1);
    rd(3'd2, r); check("setwins_cap", r, 32'h1);

    // Motor inhibit on bit 2.
    wr(3'd3, 32'h4);
    in_port = 8'h05; tick(6);
    check("inh_before", {24'h0, motor_inhibit}, 32'h0);
    tick(1);
    check("inh_set", {24'h0, motor_inhibit}, 32'h4);
    tick(2); wr(3'd4, 32'h4);
    check("inh_w1c_active", {24'h0, motor_inhibit}, 32'h4);
    in_port = 8'h01; tick(8);
    check("inh_sticky", {24'h0, motor_inhibit}, 32'h4);
    wr(3'd4, 32'h4);
    check("inh_cleared", {24'h0, motor_inhibit}, 32'h0);

    // Read latency, unmapped address and hold when deselected.
    in_port = 8'hA5; tick(8);
    rd(3'd0, r); check("read_data", r, 32'h0000_00A5);
    rd(3'd5, r); check("read_unmapped", r, 32'h0);
    rd(3'd0, r); tick(3);
    check("read_hold", readdata, 32'h0000_00A5);

    // Falling edge on bit 3.
    in_port = 8'hAD; tick(8); wr(3'd2, 32'hFF);
    in_port = 8'hA5; tick(8);
    rd(3'd2, r); check("fall_edgecap", r, FALL_CAP_EXP);

    // Reset two cycles into a debounce count on bit 4.
    in_port = 8'hB5; tick(4);
    reset = 1'b1; #1;
    check("rst_mid_readdata", readdata, 32'h0);
    check("rst_mid_irq", {31'h0, irq}, 32'h0);
    check("rst_mid_inhibit", {24'h0, motor_inhibit}, 32'h0);
    tick(2);
    reset = 1'b0; chipselect = 1'b1; address = 3'd0;
    tick(6);
    check("redebounce_before", readdata, 32'h0);
    tick(1);
    check("redebounce_at", readdata, 32'h0000_00B5);
    chipselect = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
